// File: rtl/cfg_bank_decoder_pkg.sv
// Shared types and helpers for the configuration-bank word-line decoder.
package cfg_bank_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int CNT_W     = 4;
    localparam int PAR_MAX_W = 64;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/cfg_bank_decoder_onehot.sv
// Combinational binary-to-one-hot word-line decode, forced to zero when en is low.
module decoder_onehot #(
    parameter int ADDR_W = 5,
    parameter int NUM_WL = 29
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [0:NUM_WL-1] onehot
);

    for (genvar i = 0; i < NUM_WL; i++) begin : g_line
        assign onehot[i] = en && (addr == ADDR_W'(i));
    end

endmodule

// File: rtl/cfg_bank_decoder.sv
// Sequenced configuration write: latch address/data, pulse one word line, report done/err.
// Optional build macro CFG_BANK_DECODER_PARITY_EN adds an even-parity check on each command.
module cfg_bank_decoder
    import cfg_bank_decoder_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int NUM_WL    = 29,
    parameter int DATA_W    = 1,
    parameter int PULSE_CYC = 2
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [0:ADDR_W-1] cmd_addr,
    input  logic [0:DATA_W-1] cmd_data,
`ifdef CFG_BANK_DECODER_PARITY_EN
    input  logic              cmd_parity,
`endif
    input  logic              err_clr,
    output logic [0:NUM_WL-1] wl,
    output logic [0:DATA_W-1] bl,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] NUM_WL_W = (ADDR_W+1)'(NUM_WL);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [0:DATA_W-1] bl_q, bl_d;
    logic [0:NUM_WL-1] wl_q, wl_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] addr_val;
    logic              cmd_err;
    logic              accept;

    // cmd_addr is LSB-first: index 0 carries weight 1.
    always_comb begin
        for (int i = 0; i < ADDR_W; i++) addr_val[i] = cmd_addr[i];
    end

`ifdef CFG_BANK_DECODER_PARITY_EN
    assign cmd_err = ({1'b0, addr_val} >= NUM_WL_W)
                  || (cmd_parity != even_parity(PAR_MAX_W'({cmd_addr, cmd_data})));
`else
    assign cmd_err = ({1'b0, addr_val} >= NUM_WL_W);
`endif

    assign cmd_ready = (state_q == IDLE) && enable && !prog_reset;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        // NOTE: every target gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        bl_d    = bl_q;
        err_d   = err_q;
        if (err_clr) err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // A rejected command still sets err even when err_clr is high.
                    if (cmd_err) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = addr_val;
                        bl_d    = cmd_data;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                state_d = PULSE;
                cnt_d   = CNT_W'(PULSE_CYC - 1);
            end
            PULSE: begin
                if (cnt_q == '0) state_d = HOLD;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        done_d = (state_d == HOLD);
    end

    // Decode from the next state so wl is registered in lockstep with PULSE.
    decoder_onehot #(
        .ADDR_W (ADDR_W),
        .NUM_WL (NUM_WL)
    ) u_decoder_onehot (
        .en     (state_d == PULSE),
        .addr   (addr_q),
        .onehot (wl_d)
    );

    always_ff @(posedge prog_clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch and takes effect at the next edge.
        if (prog_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            bl_q    <= '0;
            wl_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            bl_q    <= bl_d;
            wl_q    <= wl_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign wl   = wl_q;
    assign bl   = bl_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_cfg_bank_decoder.sv
// Directed self-checking bench for cfg_bank_decoder at default parameters (PULSE_CYC=2).
module tb_cfg_bank_decoder;

    localparam int ADDR_W    = 5;
    localparam int NUM_WL    = 29;
    localparam int DATA_W    = 1;
    localparam int PULSE_CYC = 2;

    logic              prog_clk;
    logic              prog_reset;
    logic              enable;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [0:ADDR_W-1] cmd_addr;
    logic [0:DATA_W-1] cmd_data;
`ifdef CFG_BANK_DECODER_PARITY_EN
    logic              cmd_parity;
`endif
    logic              err_clr;
    logic [0:NUM_WL-1] wl;
    logic [0:DATA_W-1] bl;
    logic              busy;
    logic              done;
    logic              err;

    int n_cmp = 0;
    int n_bad = 0;

    cfg_bank_decoder #(
        .ADDR_W    (ADDR_W),
        .NUM_WL    (NUM_WL),
        .DATA_W    (DATA_W),
        .PULSE_CYC (PULSE_CYC)
    ) dut (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .enable     (enable),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
`ifdef CFG_BANK_DECODER_PARITY_EN
        .cmd_parity (cmd_parity),
`endif
        .err_clr    (err_clr),
        .wl         (wl),
        .bl         (bl),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge prog_clk);
            #1;
        end
    endtask

    function automatic logic [0:ADDR_W-1] lsb_first(input int v);
        logic [0:ADDR_W-1] r;
        for (int i = 0; i < ADDR_W; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic logic [63:0] oh(input int idx);
        logic [0:NUM_WL-1] r;
        r = '0;
        r[idx] = 1'b1;
        return 64'(r);
    endfunction

    task automatic issue(input int a, input logic d);
        cmd_valid = 1'b1;
        cmd_addr  = lsb_first(a);
        cmd_data  = d;
`ifdef CFG_BANK_DECODER_PARITY_EN
        cmd_parity = ^{lsb_first(a), d};
`endif
    endtask

    initial begin
        int acc, n_acc, n_done, n_wl, multihot;
        int done_at[3];

        prog_reset = 1'b1;
        enable     = 1'b0;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_data   = '0;
        err_clr    = 1'b0;
`ifdef CFG_BANK_DECODER_PARITY_EN
        cmd_parity = 1'b0;
`endif
        tick(2);

        // Reset state
        check("rst_wl",   64'(wl), 64'd0);
        check("rst_bl",   64'(bl), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err",  64'(err), 64'd0);
        enable = 1'b1;
        #1 check("rst_ready_held_low", 64'(cmd_ready), 64'd0);
        prog_reset = 1'b0;
        #1 check("ready_after_rst", 64'(cmd_ready), 64'd1);

        // Address 5 (LSB-first 10100), data 1
        issue(5, 1'b1);
        check("a5_vec", 64'(cmd_addr), 64'b10100);
        tick();
        cmd_valid = 1'b0;
        check("a5_setup_bl",    64'(bl), 64'd1);
        check("a5_setup_wl",    64'(wl), 64'd0);
        check("a5_setup_busy",  64'(busy), 64'd1);
        check("a5_setup_ready", 64'(cmd_ready), 64'd0);
        tick();
        check("a5_pulse1_wl", 64'(wl), oh(5));
        tick();
        check("a5_pulse2_wl", 64'(wl), oh(5));
        check("a5_pulse2_done", 64'(done), 64'd0);
        tick();
        check("a5_hold_wl",   64'(wl), 64'd0);
        check("a5_hold_done", 64'(done), 64'd1);
        check("a5_hold_bl",   64'(bl), 64'd1);
        tick();
        check("a5_idle_done",  64'(done), 64'd0);
        check("a5_idle_ready", 64'(cmd_ready), 64'd1);
        check("a5_idle_busy",  64'(busy), 64'd0);

        // Highest legal address 28, data 0
        issue(28, 1'b0);
        tick();
        cmd_valid = 1'b0;
        check("a28_setup_bl", 64'(bl), 64'd0);
        tick();
        check("a28_pulse1_wl", 64'(wl), oh(28));
        tick();
        check("a28_pulse2_wl", 64'(wl), oh(28));
        tick(2);
        check("a28_idle_ready", 64'(cmd_ready), 64'd1);

        // Address 29 is out of range; data 1 must not reach bl
        issue(29, 1'b1);
        tick();
        cmd_valid = 1'b0;
        check("a29_err",   64'(err), 64'd1);
        check("a29_wl",    64'(wl), 64'd0);
        check("a29_busy",  64'(busy), 64'd0);
        check("a29_bl",    64'(bl), 64'd0);
        check("a29_done",  64'(done), 64'd0);
        check("a29_ready", 64'(cmd_ready), 64'd1);
        tick();
        check("a29_wl_later", 64'(wl), 64'd0);

        // Clear and new error in the same cycle: set wins
        issue(31, 1'b0);
        err_clr = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("clr_vs_set", 64'(err), 64'd1);
        tick();
        err_clr = 1'b0;
        check("err_cleared", 64'(err), 64'd0);

        // Three back-to-back commands with cmd_valid held high
        issue(1, 1'b1);
        n_acc = 0; n_done = 0; n_wl = 0; multihot = 0;
        for (int c = 0; c < 25; c++) begin
            acc = int'(cmd_valid && cmd_ready);
            tick();
            if (acc != 0) begin
                n_acc++;
                if (n_acc == 1) issue(12, 1'b0);
                if (n_acc == 2) issue(27, 1'b1);
                if (n_acc == 3) cmd_valid = 1'b0;
            end
            if (done) begin
                if (n_done < 3) done_at[n_done] = c;
                n_done++;
            end
            if (wl != '0) n_wl++;
            if ($countones(wl) > 1) multihot++;
        end
        check("b2b_done_count", 64'(n_done), 64'd3);
        check("b2b_gap1", 64'(done_at[1] - done_at[0]), 64'd5);
        check("b2b_gap2", 64'(done_at[2] - done_at[1]), 64'd5);
        check("b2b_wl_cycles", 64'(n_wl), 64'd6);
        check("b2b_multihot", 64'(multihot), 64'd0);

        // Reset during the second PULSE cycle discards the command
        issue(7, 1'b1);
        tick();
        cmd_valid = 1'b0;
        tick(2);
        check("rstmid_pulse2_wl", 64'(wl), oh(7));
        prog_reset = 1'b1;
        #1 check("rstmid_ready", 64'(cmd_ready), 64'd0);
        tick();
        check("rstmid_wl",   64'(wl), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_done", 64'(done), 64'd0);
        prog_reset = 1'b0;
        n_done = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done) n_done++;
        end
        check("rstmid_no_done", 64'(n_done), 64'd0);

        // enable low blocks new commands
        enable = 1'b0;
        issue(2, 1'b1);
        #1 check("dis_ready", 64'(cmd_ready), 64'd0);
        tick(2);
        check("dis_busy", 64'(busy), 64'd0);
        check("dis_wl",   64'(wl), 64'd0);
        check("dis_bl",   64'(bl), 64'd0);

        // enable dropped during SETUP: command still completes
        enable = 1'b1;
        tick();
        enable    = 1'b0;
        cmd_valid = 1'b0;
        check("en_drop_setup_busy", 64'(busy), 64'd1);
        check("en_drop_bl", 64'(bl), 64'd1);
        tick();
        check("en_drop_pulse_wl", 64'(wl), oh(2));
        tick(2);
        check("en_drop_done", 64'(done), 64'd1);
        tick();
        check("en_drop_idle_busy", 64'(busy), 64'd0);
        check("en_drop_ready_low", 64'(cmd_ready), 64'd0);
        enable = 1'b1;

`ifdef CFG_BANK_DECODER_PARITY_EN
        // Address 3, data 1: LSB-first 11000 + 1 has three ones, so good parity is 1
        issue(3, 1'b1);
        cmd_parity = 1'b0;
        tick();
        cmd_valid = 1'b0;
        check("par_bad_err",  64'(err), 64'd1);
        check("par_bad_busy", 64'(busy), 64'd0);
        tick();
        check("par_bad_wl", 64'(wl), 64'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        issue(3, 1'b1);
        check("par_good_bit", 64'(cmd_parity), 64'd1);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("par_good_wl",  64'(wl), oh(3));
        check("par_good_err", 64'(err), 64'd0);
        tick(2);
        check("par_good_done", 64'(done), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cfg_bank_decoder.md
# cfg_bank_decoder

Parametrised, sequenced successor to the fabric configuration-protocol address decoders. Accepts one configuration write per handshake: an LSB-first address and a data word. Drives the data onto the bit lines and asserts the decoded one-hot word line for a programmable pulse width. Sits between the configuration-frame sequencer and the memory-bank configuration array of one fabric region, and adds address range checking and command framing.

## Interface
- ADDR_W, default 5: address width; bit 0 is the LSB.
- NUM_WL, default 29: number of word lines; must be 2 to 2**ADDR_W.
- DATA_W, default 1: bit-line width.
- PULSE_CYC, default 2: word-line high time in prog_clk cycles; must be 1 to 15.
- prog_clk  in  1  configuration clock, sole clock.
- prog_reset  in  1  reset; synchronous and active-high.
- enable  in  1  block enable; low blocks new commands only.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_addr  in  [0:ADDR_W-1]  word-line address, index 0 = LSB.
- cmd_data  in  [0:DATA_W-1]  bit-line data.
- err_clr  in  1  clears err.
- wl  out  [0:NUM_WL-1]  one-hot word lines.
- bl  out  [0:DATA_W-1]  registered bit-line data.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse when a write completes.
- err  out  1  sticky out-of-range flag.

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD.
- cmd_ready is high exactly when state is IDLE, enable is 1 and prog_reset is 0.
- Accept occurs when cmd_valid and cmd_ready are both high.
- On accept with cmd_addr < NUM_WL:
  - Latch the address and data; bl takes cmd_data.
  - Transition IDLE→SETUP.
- SETUP: wl is all zero and bl is stable. Go to PULSE and load the pulse counter with PULSE_CYC-1.
- PULSE: wl[addr] is 1 and all other wl bits are 0. The counter decrements each cycle; at 0 go to HOLD.
- HOLD: wl is all zero and bl is held. Pulse done and go to IDLE.
- On accept with cmd_addr >= NUM_WL (an out-of-range address):
  - Set err.
  - No wl activity; bl is unchanged; no done pulse.
  - Stay in IDLE, so cmd_ready remains high the next cycle.
- err clears on err_clr. If err_clr and a new error occur in the same cycle, set wins.
- enable going low mid-command has no effect; the command completes.
- Reset values: wl=0, bl=0, busy=0, done=0, err=0, cmd_ready=0 while prog_reset=1, state IDLE.
- Reset asserted mid-PULSE: wl is all zero from the next edge and the command is discarded.

## Timing
- Accept at edge T: bl valid after T; SETUP occupies T+1.
- wl is high for cycles T+2 through T+1+PULSE_CYC.
- HOLD is at T+2+PULSE_CYC, with done high in that cycle.
- cmd_ready returns at T+3+PULSE_CYC.
- Throughput: one write per PULSE_CYC+3 cycles.
- All outputs are registered; there is no combinational path from cmd_* to wl, bl, done or err.
- cmd_ready is combinational from the state, enable and prog_reset only.
- bl changes only on accept, so it is stable for at least one cycle on each side of the wl pulse.

## Configuration
- CFG_BANK_DECODER_PARITY_EN defined:
  - Add input cmd_parity [1] carrying even parity over {cmd_addr, cmd_data}.
  - A parity mismatch on accept sets err and is handled exactly like an out-of-range address.
- Undefined: no cmd_parity port, no parity logic.

## Structure
- Package cfg_bank_decoder_pkg holds:
  - the state enum (IDLE=0, SETUP=1, PULSE=2, HOLD=3);
  - the pulse-counter width constant (4 bits);
  - a parity function.
- Sub-module decoder_onehot (parameters ADDR_W and NUM_WL): combinational address to one-hot decode, gated by an enable. The top level registers its output into wl.

## Test plan
- Defaults, accept addr=5'b10100 (value 5), data=1 → bl=1 from T+1, wl[5]=1 only for T+2 to T+3, done at T+4, cmd_ready at T+5.
- Address 28, then address 29 → address 28 pulses wl[28]; address 29 sets err, produces no wl, and cmd_ready stays 1; err_clr then drops err.
- cmd_valid held high with 3 back-to-back commands → exactly 3 done pulses, each 5 cycles apart, wl never multi-hot.
- prog_reset asserted on the second PULSE cycle → wl=0 and busy=0 at the next edge; no done pulse.
- enable=0 with cmd_valid=1 → cmd_ready=0 and no activity; enable dropped during SETUP → command completes normally.
- PARITY_EN build, bad parity on address 3 → err=1 and no wl; good parity → normal pulse on wl[3].
